alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Successor to the combinational ALU control decoder. Registers the decoded ALU control code and sequences multi-cycle operations: MUL, MaxPool, FC and Conv2d.
- Each multi-cycle operation gets a parametrised latency. The block provides valid/ready issue handshake, completion pulse, tag return and illegal-funct flag.
- Sits between ID/EX and the ALU/NN datapath. Upstream stalls on ~ready_o.

Parameters:
- CTRL_W, 4, width of ALU control code (must be >=4).
- CNT_W, 4, latency counter width.
- TAG_W, 5, width of instruction tag (e.g. rd index).
- MUL_LAT, 2, cycles for MUL (1..2^CNT_W).
- POOL_LAT, 4, cycles for MaxPool.
- FC_LAT, 8, cycles for FC.
- CONV_LAT, 9, cycles for Conv2d.
- All other ops take 1 cycle.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- flush_i  in  1  synchronous abort of in-flight op.
- valid_i  in  1  issue request.
- funct_i  in  10  {funct7[6:0], funct3[2:0]}.
- ALUOp_i  in  2  main-decoder op class.
- tag_i  in  TAG_W  tag travelling with op.
- ready_o  out  1  op accepted this cycle if valid_i.
- ALUCtrl_o  out  CTRL_W  registered control code of current/last op.
- busy_o  out  1  op in flight.
- done_o  out  1  one-cycle completion pulse.
- tag_o  out  TAG_W  tag of current/last op.
- illegal_o  out  1  current op had unmapped funct under ALUOp=10.

Behaviour:
- Decode (zero-extend codes to CTRL_W):
  - ALUOp 11 or 00 -> add 0001.
  - ALUOp 01 -> sub 0010.
  - ALUOp 10, by funct_i:
    - 0000000000 add 0001
    - 0100000000 sub 0010
    - 0000001000 MUL 0110
    - 0000000110 OR 0100
    - 0000000111 AND 0011
    - 1000000111 Relu 0111
    - 1100000111 MaxPool 1000
    - 1110000111 FC 1001
    - 1111000111 Conv2d 1010
    - anything else -> 0001 with illegal flag set.
- Latency L(op): MUL=MUL_LAT, MaxPool=POOL_LAT, FC=FC_LAT, Conv2d=CONV_LAT, else 1.
- State: IDLE, BUSY. Counter cnt[CNT_W-1:0].
- ready_o = ~flush_i & (IDLE | (BUSY & cnt==0)).
- accept = valid_i & ready_o.
- done_o = BUSY & cnt==0 & ~flush_i.
- busy_o = BUSY.
- On accept (priority below reset and flush):
  - state<=BUSY, cnt<=L(op)-1.
  - ALUCtrl_o<=decode, tag_o<=tag_i, illegal_o<=unmapped.
- BUSY & cnt!=0: cnt<=cnt-1. Inputs are ignored; ready_o=0.
- BUSY & cnt==0 & no accept: state<=IDLE. ALUCtrl_o, tag_o, illegal_o hold their values.
- Timing:
  - An op accepted at edge k pulses done_o in cycle k+L-1 after the edge, i.e. L cycles of BUSY.
  - Single-cycle ops sustain one per cycle back-to-back.
  - A multi-cycle op can be followed by a new op accepted in its done cycle (zero bubble).
- flush_i=1 at an edge:
  - state<=IDLE, cnt<=0, ALUCtrl_o<=0001, illegal_o<=0. tag_o holds.
  - No accept in that cycle; done_o forced 0 in that cycle.
- Reset (rst_n_i=0 at edge), highest priority:
  - state IDLE, cnt 0, ALUCtrl_o 0001, tag_o 0, illegal_o 0.
  - Hence ready_o=1, busy_o=0, done_o=0.
  - Reset mid-operation discards the op with no done_o.
- Outputs are stable throughout BUSY. valid_i during non-ready cycles is not queued; upstream must hold it.

Test Plan:
- Reset then idle: ready_o=1, busy_o=0, ALUCtrl_o=0001, done_o=0. Reset asserted in mid-Conv2d: done_o never pulses, ready_o=1 next cycle.
- Back-to-back single-cycle ops: ALUOp=10, funct 0100000000 then 0000000110, tags 3 and 4, valid on consecutive cycles. ALUCtrl_o=0010 then 0100, done_o high two consecutive cycles, tag_o=3 then 4.
- FC (1110000111, FC_LAT=8), valid held high:
  - busy_o 8 cycles, ALUCtrl_o=1001 stable, ready_o low for 7 cycles.
  - done_o pulses once in the 8th cycle, with a following add accepted in that same cycle.
- Illegal funct 0000000101 with ALUOp=10: ALUCtrl_o=0001, illegal_o=1, done_o after 1 cycle.
- ALUOp cases: ALUOp=01 with any funct gives 0010, L=1. ALUOp=11 with funct 1111000111 gives 0001, L=1, not Conv2d.
- flush_i on 2nd cycle of MUL (MUL_LAT=2): done_o=0 that cycle, next cycle state IDLE, ALUCtrl_o=0001. Simultaneous valid_i is not accepted.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Issue/completion bundle between the ID/EX stage and the ALU
//               operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int CTRL_W = 4,
    parameter int TAG_W  = 5
);
    logic              flush_i;
    logic              valid_i;
    logic [9:0]        funct_i;
    logic [1:0]        ALUOp_i;
    logic [TAG_W-1:0]  tag_i;
    logic              ready_o;
    logic [CTRL_W-1:0] ALUCtrl_o;
    logic              busy_o;
    logic              done_o;
    logic [TAG_W-1:0]  tag_o;
    logic              illegal_o;

    // Upstream pipeline stage issuing operations
    modport master (
        output flush_i, valid_i, funct_i, ALUOp_i, tag_i,
        input  ready_o, ALUCtrl_o, busy_o, done_o, tag_o, illegal_o
    );

    // Sequencer side
    modport slave (
        input  flush_i, valid_i, funct_i, ALUOp_i, tag_i,
        output ready_o, ALUCtrl_o, busy_o, done_o, tag_o, illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Registered ALU control decoder that sequences multi-cycle
//               operations (MUL, MaxPool, FC, Conv2d) with a valid/ready
//               issue handshake, completion pulse and tag return.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int CTRL_W   = 4,
    parameter int CNT_W    = 4,
    parameter int TAG_W    = 5,
    parameter int MUL_LAT  = 2,
    parameter int POOL_LAT = 4,
    parameter int FC_LAT   = 8,
    parameter int CONV_LAT = 9
) (
    input  wire                  clk_i,
    input  wire                  rst_n_i,
    alu_op_sequencer_if.slave    bus
);

    localparam logic [CTRL_W-1:0] CTRL_ADD  = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] CTRL_SUB  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] CTRL_AND  = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] CTRL_OR   = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] CTRL_MUL  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] CTRL_RELU = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] CTRL_POOL = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] CTRL_FC   = CTRL_W'(4'b1001);
    localparam logic [CTRL_W-1:0] CTRL_CONV = CTRL_W'(4'b1010);

    // Counter load values are latency minus one: the counter reaches zero in
    // the last BUSY cycle, which is the done cycle.
    localparam logic [CNT_W-1:0] LOAD_MUL  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] LOAD_POOL = CNT_W'(POOL_LAT - 1);
    localparam logic [CNT_W-1:0] LOAD_FC   = CNT_W'(FC_LAT - 1);
    localparam logic [CNT_W-1:0] LOAD_CONV = CNT_W'(CONV_LAT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CTRL_W-1:0]  op_ctrl;
    logic [TAG_W-1:0]   op_tag;
    logic               op_illegal;

    logic [CTRL_W-1:0]  dec_ctrl;
    logic [CNT_W-1:0]   dec_load;
    logic               dec_illegal;
    logic               last_cycle;
    logic               ready;
    logic               accept;

    // Decode ALUOp/funct into control code, counter load and illegal flag
    always_comb begin
        dec_ctrl    = CTRL_ADD;
        dec_load    = '0;
        dec_illegal = 1'b0;
        case (bus.ALUOp_i)
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                case (bus.funct_i)
                    10'b0000000000: dec_ctrl = CTRL_ADD;
                    10'b0100000000: dec_ctrl = CTRL_SUB;
                    10'b0000001000: begin dec_ctrl = CTRL_MUL;  dec_load = LOAD_MUL;  end
                    10'b0000000110: dec_ctrl = CTRL_OR;
                    10'b0000000111: dec_ctrl = CTRL_AND;
                    10'b1000000111: dec_ctrl = CTRL_RELU;
                    10'b1100000111: begin dec_ctrl = CTRL_POOL; dec_load = LOAD_POOL; end
                    10'b1110000111: begin dec_ctrl = CTRL_FC;   dec_load = LOAD_FC;   end
                    10'b1111000111: begin dec_ctrl = CTRL_CONV; dec_load = LOAD_CONV; end
                    default:        dec_illegal = 1'b1;
                endcase
            end
            default: dec_ctrl = CTRL_ADD;
        endcase
    end

    assign last_cycle = (state == BUSY) && (cnt == '0);
    assign ready      = !bus.flush_i && ((state == IDLE) || last_cycle);
    assign accept     = bus.valid_i && ready;

    // Issue/sequence FSM: reset beats flush, flush beats a new issue
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            cnt        <= '0;
            op_ctrl    <= CTRL_ADD;
            op_tag     <= '0;
            op_illegal <= 1'b0;
        end else if (bus.flush_i) begin
            state      <= IDLE;
            cnt        <= '0;
            op_ctrl    <= CTRL_ADD;
            op_illegal <= 1'b0;
        end else if (accept) begin
            state      <= BUSY;
            cnt        <= dec_load;
            op_ctrl    <= dec_ctrl;
            op_tag     <= bus.tag_i;
            op_illegal <= dec_illegal;
        end else if (state == BUSY) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.ready_o   = ready;
    assign bus.done_o    = last_cycle && !bus.flush_i;
    assign bus.busy_o    = (state == BUSY);
    assign bus.ALUCtrl_o = op_ctrl;
    assign bus.tag_o     = op_tag;
    assign bus.illegal_o = op_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Directed self-checking bench for alu_op_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_op_sequencer_if #(.CTRL_W(4), .TAG_W(5)) bus ();

    alu_op_sequencer #(
        .CTRL_W(4), .CNT_W(4), .TAG_W(5),
        .MUL_LAT(2), .POOL_LAT(4), .FC_LAT(8), .CONV_LAT(9)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle
    task automatic drive(input logic v, input logic [1:0] op, input logic [9:0] f,
                         input logic [4:0] t, input logic fl);
        bus.valid_i = v;
        bus.ALUOp_i = op;
        bus.funct_i = f;
        bus.tag_i   = t;
        bus.flush_i = fl;
        #1;
    endtask

    typedef struct {
        logic [9:0] funct;
        logic [3:0] ctrl;
        int         lat;
        logic       ill;
    } vec_t;

    vec_t vecs [10] = '{
        '{10'b0000000000, 4'b0001, 1, 1'b0},
        '{10'b0100000000, 4'b0010, 1, 1'b0},
        '{10'b0000001000, 4'b0110, 2, 1'b0},
        '{10'b0000000110, 4'b0100, 1, 1'b0},
        '{10'b0000000111, 4'b0011, 1, 1'b0},
        '{10'b1000000111, 4'b0111, 1, 1'b0},
        '{10'b1100000111, 4'b1000, 4, 1'b0},
        '{10'b1110000111, 4'b1001, 8, 1'b0},
        '{10'b1111000111, 4'b1010, 9, 1'b0},
        '{10'b1111111111, 4'b0001, 1, 1'b1}
    };

    initial begin
        int n;
        int dones;
        drive(1'b0, 2'b00, 10'd0, 5'd0, 1'b0);

        // Reset then idle
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_ready", bus.ready_o, 1);
        check("rst_busy",  bus.busy_o, 0);
        check("rst_ctrl",  bus.ALUCtrl_o, 4'b0001);
        check("rst_done",  bus.done_o, 0);
        check("rst_tag",   bus.tag_o, 0);
        check("rst_ill",   bus.illegal_o, 0);

        // Back-to-back single-cycle ops: sub tag 3, then OR tag 4
        drive(1'b1, 2'b10, 10'b0100000000, 5'd3, 1'b0);
        check("b2b_ready0", bus.ready_o, 1);
        tick();
        drive(1'b1, 2'b10, 10'b0000000110, 5'd4, 1'b0);
        check("b2b_ctrl0", bus.ALUCtrl_o, 4'b0010);
        check("b2b_tag0",  bus.tag_o, 3);
        check("b2b_done0", bus.done_o, 1);
        check("b2b_ready1", bus.ready_o, 1);
        tick();
        drive(1'b0, 2'b00, 10'd0, 5'd0, 1'b0);
        check("b2b_ctrl1", bus.ALUCtrl_o, 4'b0100);
        check("b2b_tag1",  bus.tag_o, 4);
        check("b2b_done1", bus.done_o, 1);
        tick();
        check("b2b_idle_busy", bus.busy_o, 0);
        check("b2b_idle_done", bus.done_o, 0);

        // FC with valid held high, followed by add in the done cycle
        drive(1'b1, 2'b10, 10'b1110000111, 5'd7, 1'b0);
        tick();
        for (int i = 1; i <= 7; i++) begin
            check("fc_busy",  bus.busy_o, 1);
            check("fc_ctrl",  bus.ALUCtrl_o, 4'b1001);
            check("fc_ready", bus.ready_o, 0);
            check("fc_done",  bus.done_o, 0);
            tick();
        end
        drive(1'b1, 2'b00, 10'd0, 5'd8, 1'b0);
        check("fc_done8",  bus.done_o, 1);
        check("fc_ready8", bus.ready_o, 1);
        check("fc_tag8",   bus.tag_o, 7);
        tick();
        drive(1'b0, 2'b00, 10'd0, 5'd0, 1'b0);
        check("fc_add_ctrl", bus.ALUCtrl_o, 4'b0001);
        check("fc_add_tag",  bus.tag_o, 8);
        check("fc_add_done", bus.done_o, 1);
        tick();
        check("fc_idle", bus.busy_o, 0);

        // Illegal funct under ALUOp=10
        drive(1'b1, 2'b10, 10'b0000000101, 5'd9, 1'b0);
        tick();
        drive(1'b0, 2'b00, 10'd0, 5'd0, 1'b0);
        check("ill_ctrl", bus.ALUCtrl_o, 4'b0001);
        check("ill_flag", bus.illegal_o, 1);
        check("ill_done", bus.done_o, 1);
        tick();
        check("ill_hold", bus.illegal_o, 1);
        check("ill_idle", bus.busy_o, 0);

        // ALUOp=01 and ALUOp=11 ignore funct
        drive(1'b1, 2'b01, 10'b1111000111, 5'd1, 1'b0);
        tick();
        drive(1'b1, 2'b11, 10'b1111000111, 5'd2, 1'b0);
        check("op01_ctrl", bus.ALUCtrl_o, 4'b0010);
        check("op01_done", bus.done_o, 1);
        check("op01_ill",  bus.illegal_o, 0);
        tick();
        drive(1'b0, 2'b00, 10'd0, 5'd0, 1'b0);
        check("op11_ctrl", bus.ALUCtrl_o, 4'b0001);
        check("op11_done", bus.done_o, 1);
        tick();
        check("op11_idle", bus.busy_o, 0);

        // Flush on the second cycle of MUL, with a competing valid
        drive(1'b1, 2'b10, 10'b0000001000, 5'd10, 1'b0);
        tick();
        drive(1'b0, 2'b00, 10'd0, 5'd0, 1'b0);
        check("mul_ctrl",  bus.ALUCtrl_o, 4'b0110);
        check("mul_done1", bus.done_o, 0);
        tick();
        drive(1'b1, 2'b01, 10'd0, 5'd11, 1'b1);
        check("fl_done",  bus.done_o, 0);
        check("fl_ready", bus.ready_o, 0);
        tick();
        drive(1'b0, 2'b00, 10'd0, 5'd0, 1'b0);
        check("fl_busy",  bus.busy_o, 0);
        check("fl_ctrl",  bus.ALUCtrl_o, 4'b0001);
        check("fl_tag",   bus.tag_o, 10);
        check("fl_ready_after", bus.ready_o, 1);

        // Decode and latency table
        foreach (vecs[k]) begin
            drive(1'b1, 2'b10, vecs[k].funct, 5'(k), 1'b0);
            tick();
            drive(1'b0, 2'b00, 10'd0, 5'd0, 1'b0);
            check("tbl_ctrl", bus.ALUCtrl_o, vecs[k].ctrl);
            check("tbl_ill",  bus.illegal_o, vecs[k].ill);
            n = 1;
            while (!bus.done_o && n < 20) begin
                tick();
                n++;
            end
            check("tbl_lat", n, vecs[k].lat);
            tick();
            check("tbl_idle", bus.busy_o, 0);
        end

        // Reset in the middle of Conv2d: no completion pulse
        drive(1'b1, 2'b10, 10'b1111000111, 5'd12, 1'b0);
        tick();
        drive(1'b0, 2'b00, 10'd0, 5'd0, 1'b0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.done_o) dones++;
            tick();
        end
        check("conv_busy", bus.busy_o, 1);
        check("conv_ctrl", bus.ALUCtrl_o, 4'b1010);
        rst_n = 1'b0;
        #1;
        if (bus.done_o) dones++;
        tick();
        rst_n = 1'b1;
        #1;
        check("crst_ready", bus.ready_o, 1);
        check("crst_busy",  bus.busy_o, 0);
        check("crst_ctrl",  bus.ALUCtrl_o, 4'b0001);
        check("crst_tag",   bus.tag_o, 0);
        for (int i = 0; i < 10; i++) begin
            if (bus.done_o) dones++;
            tick();
        end
        check("crst_no_done", dones, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
